// File: rtl/vars_state_array_if.sv
// Bus between the SAT bank controller and the per-variable assignment store.
// The master side issues loads, decisions, implications and backtracks; the
// slave side (the store) returns the packed assignment state and status pulses.
interface vars_state_array_if #(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_LVL = 16
);

  // Bulk load
  logic                           load_en;
  logic [NUM_VARS*3-1:0]          load_value_i;
  logic [NUM_VARS*WIDTH_LVL-1:0]  load_lvl_i;

  // Decision from the decision block (one-hot index)
  logic                           decision_done_i;
  logic [NUM_VARS-1:0]            index_decided_i;
  logic [WIDTH_LVL-1:0]           cur_lvl_i;

  // Implication from BCP (one-hot index)
  logic                           imply_valid_i;
  logic [NUM_VARS-1:0]            imply_index_i;
  logic                           imply_value_i;

  // Backtrack request
  logic                           apply_bkt_i;
  logic [WIDTH_LVL-1:0]           local_bkt_lvl_i;

  // Assignment state and status
  logic [NUM_VARS*3-1:0]          vars_value_o;
  logic [NUM_VARS*WIDTH_LVL-1:0]  vars_lvl_o;
  logic                           assign_done_o;
  logic                           conflict_o;
  logic                           bkt_done_o;
  logic                           busy_o;
  logic                           all_assigned_o;

  modport master (
    output load_en, load_value_i, load_lvl_i,
    output decision_done_i, index_decided_i, cur_lvl_i,
    output imply_valid_i, imply_index_i, imply_value_i,
    output apply_bkt_i, local_bkt_lvl_i,
    input  vars_value_o, vars_lvl_o,
    input  assign_done_o, conflict_o, bkt_done_o, busy_o, all_assigned_o
  );

  modport slave (
    input  load_en, load_value_i, load_lvl_i,
    input  decision_done_i, index_decided_i, cur_lvl_i,
    input  imply_valid_i, imply_index_i, imply_value_i,
    input  apply_bkt_i, local_bkt_lvl_i,
    output vars_value_o, vars_lvl_o,
    output assign_done_o, conflict_o, bkt_done_o, busy_o, all_assigned_o
  );

endinterface

// File: rtl/vars_state_array.sv
// Per-variable assignment store for one SAT engine bank.
// Holds a 3-bit value ({polarity[1:0], implied}) and a signed decision level
// per variable, applies decisions/implications, and clears every assignment
// above a target level through a short IDLE -> CLR -> DONE backtrack sequence.
// The array lives in flops rather than RAM: every entry is read and cleared
// in parallel during backtrack and is exported as a packed bus.
module vars_state_array #(
  parameter int NUM_VARS  = 8,
  parameter int WIDTH_LVL = 16
) (
  input  logic              clk,
  input  logic              rst,
  vars_state_array_if.slave bus
);

  localparam logic [1:0]                   POL_FREE  = 2'b00;
  localparam logic signed [WIDTH_LVL-1:0]  LVL_TOP   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]                  value_reg [NUM_VARS];
  logic [2:0]                  value_next[NUM_VARS];
  logic signed [WIDTH_LVL-1:0] lvl_reg   [NUM_VARS];
  logic signed [WIDTH_LVL-1:0] lvl_next  [NUM_VARS];
  logic signed [WIDTH_LVL-1:0] bkt_lvl_reg, bkt_lvl_next;

  logic assign_done_reg, conflict_reg, bkt_done_reg, busy_reg, all_assigned_reg;

  logic do_load, do_assign, do_clear, bkt_done_next;
  logic assign_any, conflict_any, all_assigned_next;

  logic [NUM_VARS*3-1:0]         value_pack;
  logic [NUM_VARS*WIDTH_LVL-1:0] lvl_pack;

  // Backtrack FSM: load aborts from any state; strobes only act in IDLE.
  always_comb begin
    state_next    = state_reg;
    bkt_lvl_next  = bkt_lvl_reg;
    do_load       = 1'b0;
    do_assign     = 1'b0;
    do_clear      = 1'b0;
    bkt_done_next = 1'b0;
    if (bus.load_en) begin
      do_load    = 1'b1;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.apply_bkt_i) begin
            state_next   = CLR;
            bkt_lvl_next = bus.local_bkt_lvl_i;
          end else begin
            do_assign = 1'b1;
          end
        end
        CLR: begin
          do_clear   = 1'b1;
          state_next = DONE;
        end
        DONE: begin
          bkt_done_next = 1'b1;
          state_next    = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Per-variable next state: load, backtrack clear, or decision/implication.
  always_comb begin
    assign_any        = 1'b0;
    conflict_any      = 1'b0;
    all_assigned_next = 1'b1;
    for (int k = 0; k < NUM_VARS; k++) begin
      value_next[k] = value_reg[k];
      lvl_next[k]   = lvl_reg[k];
      if (do_load) begin
        value_next[k] = bus.load_value_i[3*k +: 3];
        lvl_next[k]   = bus.load_lvl_i[WIDTH_LVL*k +: WIDTH_LVL];
      end else if (do_clear) begin
        // Signed compare: the top level (-1) is never above any target.
        if (value_reg[k][2:1] != POL_FREE && lvl_reg[k] > bkt_lvl_reg) begin
          value_next[k] = 3'b000;
          lvl_next[k]   = LVL_TOP;
        end
      end else if (do_assign) begin
        if (bus.decision_done_i && bus.index_decided_i[k]) begin
          // A decision on this variable shadows any implication on it.
          if (value_reg[k][2:1] == POL_FREE) begin
            value_next[k] = 3'b010;
            lvl_next[k]   = bus.cur_lvl_i;
            assign_any    = 1'b1;
          end
        end else if (bus.imply_valid_i && bus.imply_index_i[k]) begin
          if (value_reg[k][2:1] == POL_FREE) begin
            value_next[k] = {bus.imply_value_i, ~bus.imply_value_i, 1'b1};
            lvl_next[k]   = bus.cur_lvl_i;
            assign_any    = 1'b1;
          end else if (value_reg[k][2:1] != {bus.imply_value_i, ~bus.imply_value_i}) begin
            conflict_any = 1'b1;
          end
        end
      end
      if (value_next[k][2:1] == POL_FREE) begin
        all_assigned_next = 1'b0;
      end
    end
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      bkt_lvl_reg      <= LVL_TOP;
      assign_done_reg  <= 1'b0;
      conflict_reg     <= 1'b0;
      bkt_done_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      all_assigned_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bkt_lvl_reg      <= bkt_lvl_next;
      assign_done_reg  <= assign_any;
      conflict_reg     <= conflict_any;
      bkt_done_reg     <= bkt_done_next;
      busy_reg         <= (state_next != IDLE);
      all_assigned_reg <= all_assigned_next;
    end
  end

  // Value and level array; every variable starts free at the top level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_VARS; k++) begin
        value_reg[k] <= 3'b000;
        lvl_reg[k]   <= LVL_TOP;
      end
    end else begin
      for (int k = 0; k < NUM_VARS; k++) begin
        value_reg[k] <= value_next[k];
        lvl_reg[k]   <= lvl_next[k];
      end
    end
  end

  // Flatten the array onto the packed output buses (var k at slot k).
  always_comb begin
    value_pack = '0;
    lvl_pack   = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      value_pack[3*k +: 3]                 = value_reg[k];
      lvl_pack[WIDTH_LVL*k +: WIDTH_LVL]   = lvl_reg[k];
    end
  end

  assign bus.vars_value_o   = value_pack;
  assign bus.vars_lvl_o     = lvl_pack;
  assign bus.assign_done_o  = assign_done_reg;
  assign bus.conflict_o     = conflict_reg;
  assign bus.bkt_done_o     = bkt_done_reg;
  assign bus.busy_o         = busy_reg;
  assign bus.all_assigned_o = all_assigned_reg;

endmodule
